cpu_regfile_sb: RTL
===================

Name: cpu_regfile_sb

Overview:
Parametrised successor to the single-write, dual-read CPU register file. Adds:
- configurable width and depth
- optional hardwired zero register
- post-reset clear sweep with a ready flag
- per-register busy scoreboard for the pipeline's hazard logic
- compile-time write-to-read bypass

Sits between the decode stage (reads, issue) and the writeback stage (write, busy clear).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers (power of two, >=2)
AW, $clog2(NREG), address width (derived, not overridden)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never goes busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
ready  out  1  high once the clear sweep has completed
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
rd1  out  XLEN  read data, port 1 (combinational)
rd2  out  XLEN  read data, port 2 (combinational)
busy1  out  1  scoreboard bit for ra1 (combinational)
busy2  out  1  scoreboard bit for ra2 (combinational)
we  in  1  write enable (writeback)
wa  in  AW  write address
wd  in  XLEN  write data
iss_en  in  1  issue: mark iss_addr busy
iss_addr  in  AW  destination register of the issued instruction

Behaviour:
- Reset (rst high, asynchronous):
  - FSM goes to INIT, sweep counter = 0, ready = 0, busy vector = all 0.
  - Array contents are not reset directly.
- INIT state:
  - Each rising edge writes 0 to entry[counter], then counter++.
  - After the edge that clears entry NREG-1, FSM goes to RUN and ready = 1.
  - Sweep takes exactly NREG edges after rst deasserts.
  - we and iss_en are ignored in INIT.
  - rd1/rd2 = 0 and busy1/busy2 = 0 while ready = 0.
- rst asserted mid-sweep: sweep restarts from entry 0 after deassert.
- RUN state, write: on rising edge with we=1, entry[wa] <= wd and busy[wa] <= 0.
- RUN state, read: rd1 = entry[ra1], rd2 = entry[ra2]; busy1 = busy[ra1], busy2 = busy[ra2]. Zero cycle latency.
- Issue: on rising edge with iss_en=1, busy[iss_addr] <= 1.
- Same edge, iss_en and we, same address: busy ends at 1 (issue wins, newer producer). Data is still written.
- Same edge, iss_en and we, different addresses: both take effect independently.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Issue to address 0 is dropped.
  - Reads of address 0 return 0 with busy 0, regardless of bypass.
- Read of an address being written in the same cycle follows the bypass rule under Optional Feature.
- Busy outputs never bypass: they show the registered value.
- No write-port arbitration: one write per cycle by construction.

Optional Feature:
Macro: CPU_REGFILE_BYPASS_EN
- Defined: when ready=1, we=1 and ra1==wa (respectively ra2==wa), the port returns wd combinationally in the same cycle. Address 0 is excluded when ZERO_REG=1.
- Undefined: the port returns the stored (old) value until after the edge. Decode must stall one cycle on a write/read collision.

Test Plan:
- Reset sweep: assert rst 3 cycles, release → ready low for exactly 32 edges, high on the 33rd cycle; rd1 = 0 for every ra1 in 0..31.
- Reset mid-sweep: release rst, pulse rst after 10 edges → ready stays low until 32 edges after the second release.
- Basic write/read: write 0xDEADBEEF to r5, next cycle ra1=5, ra2=5 → rd1 = rd2 = 0xDEADBEEF. Write 0x12345678 to r0 → rd1 for ra1=0 is 0.
- Scoreboard: iss_en, iss_addr=7 → busy1 = 1 for ra1=7 next cycle. Then we, wa=7, wd=0x55 → busy1 = 0 and rd1 = 0x55 after the edge.
- Simultaneous issue and writeback to r9, with r9 previously busy → after the edge busy[9] = 1 and entry[9] = wd.
- Bypass: we, wa=3, wd=0xA5A5A5A5, ra2=3 in the same cycle → rd2 = 0xA5A5A5A5 with CPU_REGFILE_BYPASS_EN; old r3 value without it.

Source files
------------

// File: rtl/cpu_regfile_sb.sv
// Parametrised dual-read, single-write register file with post-reset clear sweep and busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining CPU_REGFILE_BYPASS_EN.
module cpu_regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr
);

  typedef enum logic {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREG];

  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [XLEN-1:0]   mem_wd;
  logic              wr_ok;
  logic              iss_ok;

  assign ready  = (state_q == StRun);
  assign wr_ok  = we && !(ZERO_REG && (wa == '0));
  assign iss_ok = iss_en && !(ZERO_REG && (iss_addr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    mem_wa  = wa;
    mem_wd  = wd;
    unique case (state_q)
      StInit: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we = wr_ok;
        if (wr_ok) begin
          busy_d[wa] = 1'b0;
        end
        // Issue applied after writeback so a newer producer keeps the register busy.
        if (iss_ok) begin
          busy_d[iss_addr] = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    logic [XLEN-1:0] val;
    val = mem_q[ra];
`ifdef CPU_REGFILE_BYPASS_EN
    if (we && (ra == wa)) begin
      val = wd;
    end
`endif
    if (!ready || (ZERO_REG && (ra == '0))) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd1   = read_port(ra1);
    rd2   = read_port(ra2);
    busy1 = ready && busy_q[ra1] && !(ZERO_REG && (ra1 == '0));
    busy2 = ready && busy_q[ra2] && !(ZERO_REG && (ra2 == '0));
  end

endmodule
